// File: rtl/mod_red_mixed_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_red_mixed_pipe (with helper mod_red_mixed_pipe_step)
// Brief    : Pipelined Montgomery reduction T = C * 2^-64 mod q for moduli
//            with q = 1 (mod 2^32). It uses two 32-bit digit steps with no q'
//            multiply, followed by one conditional subtraction.
// Revision : 1.0 - initial release
// ============================================================================

// One 32-bit Montgomery digit step: y = (x + m*q) / 2^32, where m = -x mod 2^32.
// Because q = q_H*2^32 + 1, this reduces to (x >> 32) + (x[31:0] != 0) + m*q_H.
module mod_red_mixed_pipe_step #(
    parameter int IN_W   = 120,
    parameter int OUT_W  = 89,
    parameter int Q_LEN  = 60,
    parameter int FF_SUM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   i_x,
    input  logic [Q_LEN-1:0]  i_q,
    output logic [OUT_W-1:0]  o_y,
    output logic [Q_LEN-1:0]  o_q
);
    localparam int QH_W = Q_LEN - 32;
    localparam int HI_W = IN_W - 32;

    logic [IN_W-1:0]  r_x;
    logic [Q_LEN-1:0] r_q_a;
    logic [31:0]      w_m;
    logic             w_c;
    logic [Q_LEN-1:0] w_m_ext;
    logic [Q_LEN-1:0] w_qh_ext;
    logic [Q_LEN-1:0] w_prod;
    logic [Q_LEN-1:0] r_prod;
    logic [HI_W-1:0]  r_hi;
    logic             r_c;
    logic [Q_LEN-1:0] r_q_b;
    logic [OUT_W-1:0] w_sum;

    // Operand register: capture the value to reduce together with its modulus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_q_a <= '0;
        end else begin
            r_x   <= i_x;
            r_q_a <= i_q;
        end
    end

    // The digit is the two's complement of the low word. The carry records that
    // the low word was nonzero, so that x + m*q wraps cleanly to a zero low word.
    assign w_m      = ~r_x[31:0] + 32'd1;
    assign w_c      = |r_x[31:0];
    assign w_m_ext  = {{QH_W{1'b0}}, w_m};
    assign w_qh_ext = {32'd0, r_q_a[Q_LEN-1:32]};
    assign w_prod   = w_m_ext * w_qh_ext;

    // Product register: m*q_H, with the shifted operand and carry kept alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod <= '0;
            r_hi   <= '0;
            r_c    <= 1'b0;
            r_q_b  <= '0;
        end else begin
            r_prod <= w_prod;
            r_hi   <= r_x[IN_W-1:32];
            r_c    <= w_c;
            r_q_b  <= r_q_a;
        end
    end

    // The sum is sized by the caller. Any bits above OUT_W are provably zero.
    assign w_sum = OUT_W'(r_hi) + OUT_W'(r_prod) + OUT_W'(r_c);

    generate
        if (FF_SUM != 0) begin : g_sum_reg
            logic [OUT_W-1:0] r_sum;
            logic [Q_LEN-1:0] r_q_s;
            // Optional register after the digit-step sum.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sum <= '0;
                    r_q_s <= '0;
                end else begin
                    r_sum <= w_sum;
                    r_q_s <= r_q_b;
                end
            end
            assign o_y = r_sum;
            assign o_q = r_q_s;
        end else begin : g_sum_comb
            assign o_y = w_sum;
            assign o_q = r_q_b;
        end
    endgenerate
endmodule

module mod_red_mixed_pipe #(
    parameter int K      = 120,
    parameter int Q_LEN  = 60,
    parameter int FF_SUM = 1,
    parameter int FF_SUB = 0,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Q_LEN-1:0] q,
    input  logic [K-1:0]     C,
    output logic [Q_LEN-1:0] T
);
    localparam int X1_W = K - 31;
    localparam int X2_W = Q_LEN + 1;

    logic [X1_W-1:0]  w_x1;
    logic [Q_LEN-1:0] w_q1;
    logic [X2_W-1:0]  w_x2;
    logic [Q_LEN-1:0] w_q2;
    logic [X2_W-1:0]  w_diff;
    logic             w_borrow;
    logic [Q_LEN-1:0] w_res;

    mod_red_mixed_pipe_step #(
        .IN_W   (K),
        .OUT_W  (X1_W),
        .Q_LEN  (Q_LEN),
        .FF_SUM (FF_SUM)
    ) u_step1 (
        .clk (clk),
        .rst (rst),
        .i_x (C),
        .i_q (q),
        .o_y (w_x1),
        .o_q (w_q1)
    );

    // X2 < 2q holds, so Q_LEN+1 bits are enough for the second step's result.
    mod_red_mixed_pipe_step #(
        .IN_W   (X1_W),
        .OUT_W  (X2_W),
        .Q_LEN  (Q_LEN),
        .FF_SUM (FF_SUM)
    ) u_step2 (
        .clk (clk),
        .rst (rst),
        .i_x (w_x1),
        .i_q (w_q1),
        .o_y (w_x2),
        .o_q (w_q2)
    );

    // X2 lies in [0, 2q), so the top bit of the (Q_LEN+1)-bit difference is the borrow.
    assign w_diff   = w_x2 - {1'b0, w_q2};
    assign w_borrow = w_diff[Q_LEN];

    generate
        if (FF_SUB != 0) begin : g_sub_reg
            logic [X2_W-1:0]  r_diff;
            logic [Q_LEN-1:0] r_x2_lo;
            logic [Q_LEN-1:0] r_sel;
            // Two-stage subtract: register the difference, then register the select.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_diff  <= '0;
                    r_x2_lo <= '0;
                    r_sel   <= '0;
                end else begin
                    r_diff  <= w_diff;
                    r_x2_lo <= w_x2[Q_LEN-1:0];
                    r_sel   <= r_diff[Q_LEN] ? r_x2_lo : r_diff[Q_LEN-1:0];
                end
            end
            assign w_res = r_sel;
        end else begin : g_sub_comb
            assign w_res = w_borrow ? w_x2[Q_LEN-1:0] : w_diff[Q_LEN-1:0];
        end

        if (FF_OUT != 0) begin : g_out_reg
            logic [Q_LEN-1:0] r_t;
            // Output register for the reduced result.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_t <= '0;
                end else begin
                    r_t <= w_res;
                end
            end
            assign T = r_t;
        end else begin : g_out_comb
            assign T = w_res;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_mod_red_mixed_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_red_mixed_pipe
// Brief    : Randomised, self-checking bench. It covers all eight FF_* pipeline
//            options at Q_LEN=60 and one Q_LEN=64 instance. Expected values come
//            from a modular-halving model of C * 2^-64 mod q.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_red_mixed_pipe;
    localparam int N      = 110;
    localparam int RST_A  = 62;
    localparam int RST_B  = 64;
    localparam int VEC_R  = 60;
    localparam logic [59:0] Q0  = 60'h882d43400000001;
    localparam logic [63:0] Q64 = 64'h8000118000000001;

    logic         clk = 1'b0;
    logic         rst;
    logic [59:0]  q60;
    logic [119:0] c60;
    logic [59:0]  t60 [8];
    logic [63:0]  q64;
    logic [127:0] c64;
    logic [63:0]  t64;

    logic [63:0]  exp60 [N];
    logic [63:0]  exp64 [N];
    bit           rl    [N];
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        mod_red_mixed_pipe #(
            .K(120), .Q_LEN(60),
            .FF_SUM(g % 2), .FF_SUB((g / 2) % 2), .FF_OUT((g / 4) % 2)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .q   (q60),
            .C   (c60),
            .T   (t60[g])
        );
    end

    mod_red_mixed_pipe #(
        .K(128), .Q_LEN(64), .FF_SUM(1), .FF_SUB(0), .FF_OUT(1)
    ) u_dut64 (
        .clk (clk),
        .rst (rst),
        .q   (q64),
        .C   (c64),
        .T   (t64)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // C * 2^-64 mod q: reduce C mod q, then halve 64 times modulo the odd q.
    function automatic logic [63:0] ref_t(input logic [127:0] c, input logic [63:0] qv);
        logic [127:0] x;
        if (qv == 64'd0) return 64'd0;
        x = c % {64'd0, qv};
        for (int i = 0; i < 64; i++) begin
            if (x[0]) x = (x + {64'd0, qv}) >> 1;
            else      x = x >> 1;
        end
        return x[63:0];
    endfunction

    function automatic int lat_of(input int g);
        return 4 + 2 * (g % 2) + 2 * ((g / 2) % 2) + ((g / 4) % 2);
    endfunction

    // Expected output in iteration j: the input from j-lat, or 0 if reset touched it.
    function automatic logic [63:0] exp_at(input int j, input int lat, input bit is64);
        int k;
        k = j - lat;
        if (k < 0) return 64'd0;
        for (int i = k; i < j; i++)
            if (rl[i]) return 64'd0;
        return is64 ? exp64[k] : exp60[k];
    endfunction

    task automatic rand_vec(output logic [59:0] qo, output logic [119:0] co, input bit edge_c);
        logic [31:0]  qh;
        logic [127:0] m;
        logic [127:0] r;
        logic [127:0] cmax;
        qh   = $urandom_range(32'h0FFF_FFFF, 32'h0100_0000);
        qo   = {qh[27:0], 32'h1};
        m    = {4'd0, qo, 64'd0};
        cmax = {8'd0, {120{1'b1}}};
        if (edge_c) begin
            r = (m > cmax) ? cmax : m - 128'd1;
        end else begin
            r = {8'd0, $urandom, $urandom, $urandom, $urandom};
            r[127:120] = 8'd0;
            if (r >= m) r = r % m;
        end
        co = r[119:0];
    endtask

    initial begin
        logic [127:0] one_hi;
        logic [59:0]  qr;
        logic [119:0] cr;
        one_hi = 128'd1 << 64;
        rst = 1'b1;
        q60 = '0;
        c60 = '0;
        q64 = '0;
        c64 = '0;
        #1 rst = 1'b0;

        for (int j = 0; j < N; j++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 8; g++)
                chk_eq($sformatf("T_cfg%0d_it%0d", g, j), {4'd0, t60[g]}, exp_at(j, lat_of(g), 1'b0));
            chk_eq($sformatf("T_q64_it%0d", j), t64, exp_at(j, 7, 1'b1));

            if (j == RST_A) begin
                rst = 1'b0;
                #1;
                for (int g = 0; g < 8; g++)
                    chk_eq($sformatf("T_cfg%0d_async_rst", g), {4'd0, t60[g]}, 64'd0);
                chk_eq("T_q64_async_rst", t64, 64'd0);
            end
            if (j == 4 || j == RST_B) rst = 1'b1;
            rl[j] = !rst;

            case (j)
                4, 8:   begin q60 = Q0; c60 = '0;           end
                5:      begin q60 = Q0; c60 = one_hi[119:0]; end
                6:      begin q60 = Q0; c60 = {60'd0, Q0};   end
                7, VEC_R: begin q60 = Q0; c60 = 120'd1;      end
                default: begin
                    rand_vec(qr, cr, (j % 8) == 3);
                    q60 = qr;
                    c60 = cr;
                end
            endcase
            q64 = Q64;
            case (j % 4)
                0:       c64 = one_hi;
                1:       c64 = '0;
                2:       c64 = {64'd0, Q64};
                default: c64 = 128'd1;
            endcase
            exp60[j] = ref_t({8'd0, c60}, {4'd0, q60});
            exp64[j] = ref_t(c64, q64);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
